// File: rtl/coin_ctrl_pkg.sv
// Shared types and constants for the coin-operated run controller.
package coin_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } stateT;

  localparam logic [3:0] MODE_SHORT = 4'd1;
  localparam logic [3:0] MODE_LONG  = 4'd2;
  localparam logic [3:0] CREDIT_MAX = 4'd15;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for a raw asynchronous input, followed by a
// rising-edge detector that emits a single-cycle pulse per low->high change.
module sync_edge_detect (
  input  logic Clk,
  input  logic nReset,
  input  logic rawIn,
  output logic risePulse
);

  // sh[0], sh[1] form the synchronizer; sh[2] holds the previous synced value.
  logic [2:0] sh;

  // Shift the raw input through the synchronizer and history flop.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) sh <= '0;
    else         sh <= {sh[1:0], rawIn};
  end

  assign risePulse = sh[1] & ~sh[2];

endmodule

// File: rtl/coin_run_controller.sv
// Coin/start front end for the countdown timer: banks credit, charges a run,
// arms and clears the timer, generates the tick prescaler and detects expiry.
module coin_run_controller
  import coin_ctrl_pkg::*;
#(
  parameter int PRICE    = 2,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        CoinIn,
  input  logic        Start,
  input  logic [3:0]  ModeSel,
  input  logic [11:0] PresentTime,
  output logic [3:0]  CounterInput,
  output logic        CounterEnable,
  output logic        CounterClear_n,
  output logic [3:0]  Credit,
  output logic        Busy,
  output logic        Done
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0]      PRICE5    = 5'(PRICE);

  stateT         state;
  logic          coinEv;
  logic          startEv;
  logic [PW-1:0] presc;
  logic          seenNz;
  logic          startOk;
  logic [4:0]    creditSum;
  logic [3:0]    creditNext;

  sync_edge_detect uCoinSync (
    .Clk       (Clk),
    .nReset    (nReset),
    .rawIn     (CoinIn),
    .risePulse (coinEv)
  );

  sync_edge_detect uStartSync (
    .Clk       (Clk),
    .nReset    (nReset),
    .rawIn     (Start),
    .risePulse (startEv)
  );

  // Credit arithmetic done 5 bits wide so a coin at 15 can be clamped and a
  // coin landing together with a paid start nets out before clamping.
  always_comb begin
    startOk   = (state == IDLE) && startEv && ({1'b0, Credit} >= PRICE5);
    creditSum = {1'b0, Credit} + {4'd0, coinEv};
    if (startOk) creditSum = creditSum - PRICE5;
    creditNext = (creditSum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : creditSum[3:0];
  end

  // Banked credit register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) Credit <= '0;
    else         Credit <= creditNext;
  end

  // Run FSM with registered outputs, prescaler and expiry tracking.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state          <= IDLE;
      CounterInput   <= MODE_LONG;
      CounterEnable  <= 1'b0;
      CounterClear_n <= 1'b1;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      presc          <= '0;
      seenNz         <= 1'b0;
    end else begin
      CounterEnable  <= 1'b0;
      CounterClear_n <= 1'b1;
      case (state)
        IDLE: begin
          if (startOk) begin
            state          <= ARM;
            CounterInput   <= (ModeSel == MODE_SHORT) ? MODE_SHORT : MODE_LONG;
            CounterClear_n <= 1'b0;
            Busy           <= 1'b1;
          end
        end
        ARM: begin
          presc  <= '0;
          seenNz <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          // Only a zero that follows a nonzero reading counts as expiry, so the
          // freshly cleared timer does not end the run immediately.
          if (seenNz && (PresentTime == '0)) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            if (PresentTime != '0) seenNz <= 1'b1;
            if (presc == TICK_LAST) begin
              presc         <= '0;
              CounterEnable <= 1'b1;
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        DONE: begin
          if (startEv) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_run_controller.sv
// Scoreboard bench for coin_run_controller (PRICE=2, TICK_DIV=4).
// Stimulus pushes expected output snapshots (tagged with the cycle they are
// due) and expected tick cycles; monitors pop and compare at negedges.
module tb_coin_run_controller;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        CoinIn = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  ModeSel = 4'd0;
  logic [11:0] PresentTime = 12'd0;
  logic [3:0]  CounterInput;
  logic        CounterEnable;
  logic        CounterClear_n;
  logic [3:0]  Credit;
  logic        Busy;
  logic        Done;

  coin_run_controller #(.PRICE(2), .TICK_DIV(4)) dut (
    .Clk            (Clk),
    .nReset         (nReset),
    .CoinIn         (CoinIn),
    .Start          (Start),
    .ModeSel        (ModeSel),
    .PresentTime    (PresentTime),
    .CounterInput   (CounterInput),
    .CounterEnable  (CounterEnable),
    .CounterClear_n (CounterClear_n),
    .Credit         (Credit),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #5 Clk = ~Clk;

  // Snapshot layout: {Credit, CounterInput, CounterEnable, CounterClear_n, Busy, Done}
  typedef struct {
    int          cyc;
    string       tag;
    logic [11:0] exp;
  } expT;

  expT  sbQ[$];
  int   tickQ[$];
  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;

  function automatic logic [11:0] snap();
    return {Credit, CounterInput, CounterEnable, CounterClear_n, Busy, Done};
  endfunction

  function automatic logic [11:0] mk(input int cr, input int ci, input bit en,
                                     input bit clr, input bit busy, input bit done);
    return {4'(cr), 4'(ci), en, clr, busy, done};
  endfunction

  task automatic cmp(input string tag, input logic [11:0] act, input logic [11:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got cr=%0d ci=%0d en=%b clr=%b busy=%b done=%b, expected cr=%0d ci=%0d en=%b clr=%b busy=%b done=%b",
               tag, act[11:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic expectAt(input int c, input string tag, input logic [11:0] e);
    expT x;
    x.cyc = c; x.tag = tag; x.exp = e;
    sbQ.push_back(x);
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Snapshot monitor: compares every expectation due this cycle.
  always @(negedge Clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      if (sbQ[0].cyc < cyc) begin
        nChecks++; nFails++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", sbQ[0].tag, sbQ[0].cyc, cyc);
      end else begin
        cmp(sbQ[0].tag, snap(), sbQ[0].exp);
      end
      void'(sbQ.pop_front());
    end
  end

  // Tick monitor: every CounterEnable pulse must match the next expected cycle.
  always @(negedge Clk) begin
    while (tickQ.size() > 0 && tickQ[0] < cyc) begin
      nChecks++; nFails++;
      $display("FAIL tick: no pulse at cycle %0d, required 1", tickQ[0]);
      void'(tickQ.pop_front());
    end
    if (CounterEnable) begin
      nChecks++;
      if (tickQ.size() > 0 && tickQ[0] == cyc) begin
        void'(tickQ.pop_front());
      end else begin
        nFails++;
        $display("FAIL tick: pulse at cycle %0d, required 0", cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge Clk); #1; end
  endtask

  task automatic waitCyc(input int t);
    while (cyc < t) tick(1);
  endtask

  // Rising edge on the selected raw inputs, held 2 cycles high then 2 low.
  task automatic pulse(input bit c, input bit s);
    CoinIn = c; Start = s;
    tick(2);
    CoinIn = 1'b0; Start = 1'b0;
    tick(2);
  endtask

  initial begin
    int n;
    tick(1);

    // Reset held: toggling inputs must not disturb reset values.
    CoinIn = 1'b1; Start = 1'b1; tick(2);
    CoinIn = 1'b0; Start = 1'b0; tick(1);
    CoinIn = 1'b1; tick(1); CoinIn = 1'b0;
    expectAt(cyc + 1, "reset_hold", mk(0, 2, 0, 1, 0, 0));
    tick(2);
    nReset = 1'b1;
    tick(3);

    // Price gating.
    pulse(1, 0);
    expectAt(cyc + 1, "one_coin", mk(1, 2, 0, 1, 0, 0));
    tick(1);
    pulse(0, 1);
    expectAt(cyc + 1, "start_short_credit", mk(1, 2, 0, 1, 0, 0));
    tick(1);
    pulse(1, 0);
    expectAt(cyc + 1, "two_coins", mk(2, 2, 0, 1, 0, 0));
    tick(1);

    // Paid start, short mode: ARM one cycle, ticks every 4 cycles.
    ModeSel = 4'd1;
    n = cyc;
    expectAt(n + 3, "arm_short", mk(0, 1, 0, 0, 1, 0));
    expectAt(n + 4, "run_short", mk(0, 1, 0, 1, 1, 0));
    tickQ.push_back(n + 8); tickQ.push_back(n + 12); tickQ.push_back(n + 16);
    pulse(0, 1);
    expectAt(n + 17, "run_after_ticks", mk(0, 1, 0, 1, 1, 0));
    waitCyc(n + 17);
    PresentTime = 12'h159;
    expectAt(n + 18, "run_nonzero", mk(0, 1, 0, 1, 1, 0));
    waitCyc(n + 18);
    PresentTime = 12'h000;
    expectAt(n + 19, "expiry_done", mk(0, 1, 0, 1, 0, 1));
    expectAt(n + 30, "done_holds", mk(0, 1, 0, 1, 0, 1));
    waitCyc(n + 30);
    pulse(0, 1);
    expectAt(cyc + 1, "done_to_idle", mk(0, 1, 0, 1, 0, 0));
    tick(1);

    // Saturation and banking.
    repeat (17) pulse(1, 0);
    expectAt(cyc + 1, "saturate_15", mk(15, 1, 0, 1, 0, 0));
    tick(1);
    ModeSel = 4'd7;
    n = cyc;
    expectAt(n + 3, "arm_long", mk(13, 2, 0, 0, 1, 0));
    expectAt(n + 4, "run_long", mk(13, 2, 0, 1, 1, 0));
    tickQ.push_back(n + 8);
    pulse(0, 1);
    pulse(1, 0);
    expectAt(n + 9, "coin_in_run", mk(14, 2, 0, 1, 1, 0));
    waitCyc(n + 10);
    PresentTime = 12'h005;
    waitCyc(n + 11);
    PresentTime = 12'h000;
    // Expiry lands on the cycle that would otherwise tick: enable stays low.
    expectAt(n + 12, "expiry_on_tick", mk(14, 2, 0, 1, 0, 1));
    waitCyc(n + 14);
    pulse(1, 0);
    expectAt(cyc + 1, "coin_in_done", mk(15, 2, 0, 1, 0, 1));
    tick(1);
    pulse(0, 1);
    expectAt(cyc + 1, "done_to_idle_2", mk(15, 2, 0, 1, 0, 0));
    tick(1);

    // Coin and start together at full credit: 15 + 1 - 2 = 14.
    n = cyc;
    expectAt(n + 3, "coin_start_same", mk(14, 2, 0, 0, 1, 0));
    expectAt(n + 4, "run_3", mk(14, 2, 0, 1, 1, 0));
    tickQ.push_back(n + 8);
    pulse(1, 1);

    // Asynchronous reset mid-run, between clock edges.
    waitCyc(n + 10);
    #3;
    nReset = 1'b0;
    #1;
    cmp("async_reset", snap(), mk(0, 2, 0, 1, 0, 0));
    tick(2);
    nReset = 1'b1;
    expectAt(cyc + 1, "after_reset", mk(0, 2, 0, 1, 0, 0));
    tick(1);
    pulse(0, 1);
    expectAt(cyc + 1, "start_no_credit", mk(0, 2, 0, 1, 0, 0));
    tick(6);

    while (sbQ.size() > 0) begin
      nChecks++; nFails++;
      $display("FAIL %s: check never reached", sbQ[0].tag);
      void'(sbQ.pop_front());
    end
    while (tickQ.size() > 0) begin
      nChecks++; nFails++;
      $display("FAIL tick: expected pulse at cycle %0d never seen", tickQ[0]);
      void'(tickQ.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/coin_run_controller.md
# coin_run_controller

Upstream control stage for the countdown timer. Turns raw coin and start inputs into a paid run. It accepts and banks coins, deducts the price on a valid start, latches the run mode, and clears/re-arms the timer. While running it issues a one-cycle 1 Hz tick on `CounterEnable`, and it watches the timer's `PresentTime` to detect expiry.

## Interface
Parameters:
- `PRICE`, default 2: coins deducted per run (1..15).
- `TICK_DIV`, default 50_000_000: `Clk` cycles per timer tick (≥2). The prescaler is `$clog2(TICK_DIV)` bits wide.

Ports (clock and reset first):
- `Clk`  in  1  system clock. Single clock domain.
- `nReset`  in  1  reset, asynchronous, active-low.
- `CoinIn`  in  1  raw coin sensor, asynchronous. Each rising edge is one coin.
- `Start`  in  1  raw start button, asynchronous. Each rising edge is one start request.
- `ModeSel`  in  4  requested mode. 4'd1 is short (1:59); any other value is long.
- `PresentTime`  in  12  timer value fed back from the countdown timer.
- `CounterInput`  out  4  latched run mode: 4'd1 short, 4'd2 long.
- `CounterEnable`  out  1  one-cycle tick pulse to the timer.
- `CounterClear_n`  out  1  one-cycle active-low clear. The top level ANDs it with `nReset` to drive the timer reset.
- `Credit`  out  4  banked coins.
- `Busy`  out  1  high in ARM and RUN.
- `Done`  out  1  high in DONE.

## Operation
- **Input conditioning.** `CoinIn` and `Start` each pass through a 2-flop synchronizer and a rising-edge detector. Each detector produces a one-cycle event (`coin_ev`, `start_ev`).
- **Credit.**
  - `coin_ev` increments `Credit` in every state. `Credit` saturates at 15.
  - When a coin and a valid start occur in the same cycle, the new credit is `Credit + 1 - PRICE`, clamped to 15.
- **States:** IDLE, ARM, RUN, DONE.
- **IDLE**
  - `start_ev` with `Credit >= PRICE`:
    - deduct PRICE;
    - latch `CounterInput` (1 if `ModeSel == 1`, else 2);
    - go to ARM.
  - `start_ev` with `Credit < PRICE` is ignored. No state change, no deduction.
- **ARM** (exactly one cycle)
  - `CounterClear_n = 0`, `Busy = 1`.
  - The prescaler is zeroed and `seen_nz` is cleared.
  - Next state is RUN.
- **RUN**
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - `CounterEnable = 1` for one cycle when the prescaler equals TICK_DIV-1.
  - `seen_nz` is set whenever `PresentTime != 0`.
  - Expiry is `seen_nz && PresentTime == 0`. On expiry:
    - go to DONE;
    - `CounterEnable` is forced to 0 in that cycle;
    - the prescaler holds.
  - `start_ev` in RUN is ignored. There is no abort.
- **DONE**
  - `Done = 1`, `Busy = 0`, no ticks.
  - `start_ev` returns to IDLE and is consumed; it does not start a run.
  - `coin_ev` in DONE is credited but does not leave DONE.
- **Mode latch.** `CounterInput` changes only on the IDLE→ARM transition. After a run it holds its last value.
- **Reset.**
  - Asserting `nReset` at any time, including mid-RUN, immediately forces: state IDLE, `Credit = 0`, `CounterInput = 4'd2`, `CounterEnable = 0`, `CounterClear_n = 1`, `Busy = 0`, `Done = 0`.
  - Prescaler, `seen_nz` and synchronizer flops also reset to 0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Raw `CoinIn` rise sampled at edge k: `Credit` updates after edge k+2. `start_ev` has the same 2-cycle latency.
- `start_ev` seen in IDLE: `CounterClear_n` goes low and `Busy` goes high on the next edge, for exactly one cycle.
- First `CounterEnable` pulse: TICK_DIV cycles after entering RUN. Subsequent pulses are exactly TICK_DIV apart.
- Expiry is registered: `Done` rises one cycle after `PresentTime` reads 0 with `seen_nz` set.
- Level inputs held high produce one event only. A new event requires a low period of at least 1 cycle after synchronization.

## Structure
- **Package `coin_ctrl_pkg`:**
  - state enum (IDLE, ARM, RUN, DONE);
  - `MODE_SHORT = 4'd1`, `MODE_LONG = 4'd2`;
  - `CREDIT_MAX = 4'd15`.
- **Sub-module `sync_edge_detect`:** 2-flop synchronizer plus rising-edge pulse, async active-low reset. It is instantiated twice, for `CoinIn` and `Start`.
- **Top file:** FSM, credit register, prescaler, expiry detect.

## Test plan
- **Reset.** Hold `nReset = 0`, toggle inputs → all outputs at reset values (`CounterInput = 2`, `CounterClear_n = 1`, the rest 0).
- **Price gating** (PRICE=2). One coin, then Start → `Credit = 1`, `Busy` stays 0. Second coin → `Credit = 2`. Start with `ModeSel = 1` → `Credit = 0`, `CounterClear_n` low for 1 cycle, `CounterInput = 1`, `Busy = 1`.
- **Tick cadence** (TICK_DIV=4). After ARM, `CounterEnable` pulses on RUN cycles 4, 8, 12, each exactly 1 cycle wide. `ModeSel = 7` latches `CounterInput = 2`.
- **Expiry.** Timer model drives `PresentTime` nonzero, then 12'h000 → `Done = 1` the next cycle, `Busy = 0`, no further ticks. Start → IDLE, `Credit` unchanged.
- **Saturation and banking.** 17 coins in IDLE → `Credit = 15`. Start deducts 2 → 13. Coin during RUN → 14. Coin and Start in the same cycle with `Credit = 15` → 14.
- **Reset mid-run.** Pull `nReset` low in RUN between clock edges → outputs reach reset values immediately, without waiting for a `Clk` edge. Release → IDLE, `Credit = 0`.
